// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch front-panel controller.
package stopwatch_pkg;

  localparam int unsigned TimeW = 6;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StLap    = 2'd2,
    StPaused = 2'd3
  } sw_state_e;

endpackage

// File: rtl/btn_conditioner.sv
// Raw button -> 2-FF synchroniser -> debounce counter -> registered rising-edge press pulse.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Once the counter has reached its limit the level flips even if the input has just
  // dropped again, so a pulse of exactly DEBOUNCE_CYCLES cycles still counts.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (cnt_q == CntMax) begin
      deb_d = ~deb_q;
    end else if (sync2_q != deb_q) begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = deb_d & ~deb_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front panel: conditions two buttons, sequences start/stop/clear, owns lap display.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIME_W          = TimeW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_ss,
  input  logic              btn_lr,
  input  logic [TIME_W-1:0] sw_sec,
  input  logic [TIME_W-1:0] sw_min,
  output logic              sw_start,
  output logic              sw_stop,
  output logic              sw_clear,
  output logic [TIME_W-1:0] disp_sec,
  output logic [TIME_W-1:0] disp_min,
  output logic              lap_active,
  output logic [1:0]        state
);

  logic press_ss, press_lr;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cond_ss (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_ss),
    .press  (press_ss)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cond_lr (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_lr),
    .press  (press_lr)
  );

  sw_state_e         state_q, state_d;
  logic              start_q, start_d, stop_q, stop_d, clear_q, clear_d;
  logic              lap_q, lap_d;
  logic [TIME_W-1:0] disp_sec_q, disp_sec_d, disp_min_q, disp_min_d;

  // ss wins over lr; a simultaneous lr press is simply discarded.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    clear_d = 1'b0;
    lap_d   = lap_q;
    unique case (state_q)
      StIdle: begin
        if (press_ss) begin
          start_d = 1'b1;
          state_d = StRun;
        end else if (press_lr) begin
          clear_d = 1'b1;
        end
      end
      StRun: begin
        if (press_ss) begin
          stop_d  = 1'b1;
          state_d = StPaused;
        end else if (press_lr) begin
          lap_d   = 1'b1;
          state_d = StLap;
        end
      end
      StLap: begin
        if (press_ss) begin
          stop_d  = 1'b1;
          lap_d   = 1'b0;
          state_d = StPaused;
        end else if (press_lr) begin
          lap_d   = 1'b0;
          state_d = StRun;
        end
      end
      StPaused: begin
        if (press_ss) begin
          start_d = 1'b1;
          state_d = StRun;
        end else if (press_lr) begin
          clear_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // The edge entering LAP still samples live time, which is exactly the lap latch.
    disp_sec_d = lap_q ? disp_sec_q : sw_sec;
    disp_min_d = lap_q ? disp_min_q : sw_min;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      clear_q    <= 1'b0;
      lap_q      <= 1'b0;
      disp_sec_q <= '0;
      disp_min_q <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      clear_q    <= clear_d;
      lap_q      <= lap_d;
      disp_sec_q <= disp_sec_d;
      disp_min_q <= disp_min_d;
    end
  end

  assign sw_start   = start_q;
  assign sw_stop    = stop_q;
  assign sw_clear   = clear_q;
  assign lap_active = lap_q;
  assign disp_sec   = disp_sec_q;
  assign disp_min   = disp_min_q;
  assign state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: expected FSM events queued at stimulus time.
module tb_stopwatch_ctrl;

  localparam int Deb = 4;
  localparam int Lat = Deb + 3;
  localparam int TW  = 6;

  localparam logic [2:0] CmdNone  = 3'b000;
  localparam logic [2:0] CmdStart = 3'b100;
  localparam logic [2:0] CmdStop  = 3'b010;
  localparam logic [2:0] CmdClear = 3'b001;

  localparam logic [1:0] SIdle   = 2'd0;
  localparam logic [1:0] SRun    = 2'd1;
  localparam logic [1:0] SLap    = 2'd2;
  localparam logic [1:0] SPaused = 2'd3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          btn_ss = 1'b0;
  logic          btn_lr = 1'b0;
  logic [TW-1:0] sw_sec = '0;
  logic [TW-1:0] sw_min = '0;
  logic          sw_start, sw_stop, sw_clear, lap_active;
  logic [TW-1:0] disp_sec, disp_min;
  logic [1:0]    state;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(Deb),
    .TIME_W         (TW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_ss    (btn_ss),
    .btn_lr    (btn_lr),
    .sw_sec    (sw_sec),
    .sw_min    (sw_min),
    .sw_start  (sw_start),
    .sw_stop   (sw_stop),
    .sw_clear  (sw_clear),
    .disp_sec  (disp_sec),
    .disp_min  (disp_min),
    .lap_active(lap_active),
    .state     (state)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  typedef struct {
    int         cyc;
    logic [2:0] cmd;
    logic [1:0] st;
    logic       lap;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Any command pulse or state change is an event and must match the queue head.
  logic [1:0] prev_st = 2'd0;
  always @(negedge clk) begin
    logic [2:0] cmd;
    exp_t       e;
    cmd = {sw_start, sw_stop, sw_clear};
    if (rst_seen) begin
      prev_st = state;
    end else begin
      if (cmd != CmdNone || state != prev_st) begin
        check_eq("cmd_onehot", 32'($countones(cmd) <= 1), 32'd1);
        if (sb.size() == 0) begin
          check_eq("event_expected", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check_eq("event_cycle", cyc, e.cyc);
          check_eq("event_cmd", 32'(cmd), 32'(e.cmd));
          check_eq("event_state", 32'(state), 32'(e.st));
          check_eq("event_lap", 32'(lap_active), 32'(e.lap));
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        check_eq("event_missing", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      prev_st = state;
    end
  end

  // Called at a negedge; the next posedge is the first to sample the button.
  task automatic press(input bit ss, input bit lr, input int hold, input logic [2:0] cmd,
                       input logic [1:0] st, input logic lap, input bit ev);
    btn_ss = ss;
    btn_lr = lr;
    if (ev) sb.push_back('{cyc + Lat + 1, cmd, st, lap});
    repeat (hold) @(negedge clk);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"}, 32'(state), 32'(SIdle));
    check_eq({tag, "_cmd"}, 32'({sw_start, sw_stop, sw_clear}), 32'(CmdNone));
    check_eq({tag, "_lap"}, 32'(lap_active), 32'd0);
    check_eq({tag, "_disp"}, 32'({disp_min, disp_sec}), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_init");
    reset = 1'b0;
    @(negedge clk);

    // Long press from IDLE: single start, exact latency.
    press(1'b1, 1'b0, 20, CmdStart, SRun, 1'b0, 1'b1);
    check_eq("run_state", 32'(state), 32'(SRun));

    // Short glitch is ignored; a DEBOUNCE_CYCLES-long pulse counts.
    press(1'b1, 1'b0, Deb - 1, CmdNone, SRun, 1'b0, 1'b0);
    check_eq("glitch_state", 32'(state), 32'(SRun));
    press(1'b1, 1'b0, Deb, CmdStop, SPaused, 1'b0, 1'b1);
    press(1'b1, 1'b0, 6, CmdStart, SRun, 1'b0, 1'b1);

    // Lap freeze while live time advances and wraps.
    sw_sec = 6'd12;
    sw_min = 6'd1;
    press(1'b0, 1'b1, 6, CmdNone, SLap, 1'b1, 1'b1);
    check_eq("lap_active", 32'(lap_active), 32'd1);
    sw_sec = 6'd55;
    sw_min = 6'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("lap_sec_hold", 32'(disp_sec), 32'd12);
      check_eq("lap_min_hold", 32'(disp_min), 32'd1);
      sw_sec = (sw_sec == 6'd59) ? 6'd0 : sw_sec + 6'd1;
    end
    press(0, 1'b1, 6, CmdNone, SRun, 1'b0, 1'b1);
    sw_sec = 6'd40;
    sw_min = 6'd3;
    @(negedge clk);
    check_eq("live_sec", 32'(disp_sec), 32'd40);
    check_eq("live_min", 32'(disp_min), 32'd3);

    // Full command walk.
    press(1'b1, 1'b0, 6, CmdStop, SPaused, 1'b0, 1'b1);
    press(1'b0, 1'b1, 6, CmdClear, SIdle, 1'b0, 1'b1);
    press(1'b0, 1'b1, 6, CmdClear, SIdle, 1'b0, 1'b1);
    press(1'b1, 1'b0, 6, CmdStart, SRun, 1'b0, 1'b1);

    // Simultaneous presses in RUN: ss wins, lr dropped.
    press(1'b1, 1'b1, 8, CmdStop, SPaused, 1'b0, 1'b1);
    check_eq("simul_state", 32'(state), 32'(SPaused));
    check_eq("simul_lap", 32'(lap_active), 32'd0);

    // Reset in LAP with ss mid-debounce and held through reset.
    press(1'b1, 1'b0, 6, CmdStart, SRun, 1'b0, 1'b1);
    press(1'b0, 1'b1, 6, CmdNone, SLap, 1'b1, 1'b1);
    btn_ss = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid");
    @(negedge clk);
    reset = 1'b0;
    sb.push_back('{cyc + Lat + 1, CmdStart, SRun, 1'b0});
    repeat (20) @(negedge clk);
    btn_ss = 1'b0;
    repeat (14) @(negedge clk);
    check_eq("post_reset_state", 32'(state), 32'(SRun));

    repeat (5) @(negedge clk);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
